// File: rtl/movavg_param.sv
// Moving sum / moving average over a window of 2^LOG2_TAPS samples.
// Registered output with valid strobe, window-full flag and synchronous history clear.
module movavg_param #(
    parameter int WIDTH     = 64,
    parameter int LOG2_TAPS = 2,
    parameter int AVG_MODE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             dout_valid,
    output logic [WIDTH-1:0] dout,
    output logic             full
);
    localparam int TAPS = 1 << LOG2_TAPS;
    localparam int AW   = WIDTH + LOG2_TAPS;
    localparam logic [LOG2_TAPS:0] TAPS_C = (LOG2_TAPS + 1)'(TAPS);

    logic [WIDTH-1:0]     hist [TAPS];
    logic [AW-1:0]        acc;
    logic [LOG2_TAPS-1:0] wptr;
    logic [LOG2_TAPS:0]   cnt;

    logic [AW-1:0]        acc_next;
    logic [LOG2_TAPS:0]   cnt_next;

    // acc carries LOG2_TAPS guard bits so the window sum is exact; wrap only happens at dout.
    function automatic logic [WIDTH-1:0] scale(input logic [AW-1:0] s);
        if (AVG_MODE != 0) return s[AW-1:LOG2_TAPS];
        else               return s[WIDTH-1:0];
    endfunction

    always_comb begin
        acc_next = acc + AW'(din) - AW'(hist[wptr]);
        cnt_next = (cnt == TAPS_C) ? cnt : cnt + (LOG2_TAPS + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
            acc        <= '0;
            wptr       <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
            dout_valid <= din_valid;
            if (din_valid) begin
                // din restarts the window as its first sample
                hist[0] <= din;
                acc     <= AW'(din);
                wptr    <= LOG2_TAPS'(1);
                cnt     <= (LOG2_TAPS + 1)'(1);
                dout    <= scale(AW'(din));
            end else begin
                acc  <= '0;
                wptr <= '0;
                cnt  <= '0;
            end
        end else if (din_valid) begin
            hist[wptr] <= din;
            acc        <= acc_next;
            wptr       <= wptr + LOG2_TAPS'(1);
            cnt        <= cnt_next;
            dout       <= scale(acc_next);
            dout_valid <= 1'b1;
        end else begin
            dout_valid <= 1'b0;
        end
    end

    assign full = (cnt == TAPS_C);

endmodule

// File: tb/tb_movavg_param.sv
// Bench for movavg_param: four instances (64b/4-tap and 16b/8-tap, sum and average)
// share one stimulus stream and are checked against a queue-of-samples window model.
module tb_movavg_param;
    logic        clk = 1'b0;
    logic        reset, clear, din_valid;
    logic [63:0] din;

    logic [63:0] d0, d1;
    logic [15:0] d2, d3;
    logic        v0, v1, v2, v3, f0, f1, f2, f3;

    logic [63:0] obs_dout [4];
    logic        obs_v    [4];
    logic        obs_full [4];

    localparam int CW [4] = '{64, 64, 16, 16};
    localparam int CL [4] = '{2, 2, 3, 3};
    localparam int CM [4] = '{0, 1, 0, 1};

    int checks = 0;
    int errors = 0;

    logic [63:0] q [$];
    logic [63:0] exp_dout [4];
    logic        exp_full [4];
    logic        exp_v;

    always #5 clk = ~clk;

    movavg_param #(.WIDTH(64), .LOG2_TAPS(2), .AVG_MODE(0)) u0 (
        .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
        .dout_valid(v0), .dout(d0), .full(f0));
    movavg_param #(.WIDTH(64), .LOG2_TAPS(2), .AVG_MODE(1)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
        .dout_valid(v1), .dout(d1), .full(f1));
    movavg_param #(.WIDTH(16), .LOG2_TAPS(3), .AVG_MODE(0)) u2 (
        .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din[15:0]),
        .dout_valid(v2), .dout(d2), .full(f2));
    movavg_param #(.WIDTH(16), .LOG2_TAPS(3), .AVG_MODE(1)) u3 (
        .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din[15:0]),
        .dout_valid(v3), .dout(d3), .full(f3));

    assign obs_dout[0] = d0;
    assign obs_dout[1] = d1;
    assign obs_dout[2] = {48'b0, d2};
    assign obs_dout[3] = {48'b0, d3};
    assign obs_v[0] = v0;
    assign obs_v[1] = v1;
    assign obs_v[2] = v2;
    assign obs_v[3] = v3;
    assign obs_full[0] = f0;
    assign obs_full[1] = f1;
    assign obs_full[2] = f2;
    assign obs_full[3] = f3;

    // Window model: expected output is the sum of the newest 2^L accepted samples since
    // the last reset/clear, truncated to the instance width, divided by 2^L in average mode.
    task automatic model_eval();
        for (int i = 0; i < 4; i++) begin
            logic [79:0] sum, m;
            int n;
            n   = 1 << CL[i];
            m   = (CW[i] == 64) ? {16'b0, {64{1'b1}}} : (80'd1 << CW[i]) - 80'd1;
            sum = '0;
            for (int k = q.size() - n; k < q.size(); k++)
                if (k >= 0) sum += {16'b0, q[k]} & m;
            if (CM[i] != 0) sum = sum >> CL[i];
            sum         = sum & m;
            exp_dout[i] = sum[63:0];
            exp_full[i] = (q.size() >= n);
        end
    endtask

    // Drive one cycle of inputs, advance the model, and settle 1ns past the edge.
    task automatic drive(input logic v, input logic [63:0] d, input logic c, input logic r);
        din_valid = v;
        din       = d;
        clear     = c;
        reset     = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            for (int i = 0; i < 4; i++) begin
                exp_dout[i] = '0;
                exp_full[i] = 1'b0;
            end
            exp_v = 1'b0;
        end else if (c) begin
            q.delete();
            if (v) begin
                q.push_back(d);
                model_eval();
            end else begin
                for (int i = 0; i < 4; i++) exp_full[i] = 1'b0;
            end
            exp_v = v;
        end else if (v) begin
            q.push_back(d);
            while (q.size() > 8) void'(q.pop_front());
            model_eval();
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        #1;
        din_valid = 1'b0;
        clear     = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_dout[i] !== 64'd0 || obs_v[i] !== 1'b0 || obs_full[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d got dout=%0h v=%b full=%b exp 0/0/0",
                         i, obs_dout[i], obs_v[i], obs_full[i]);
            end
        end
    endtask

    task automatic test_fill();
        logic [63:0] exp [6];
        exp = '{64'd1, 64'd3, 64'd6, 64'd10, 64'd14, 64'd18};
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 64'(i + 1), 1'b0, 1'b0);
            checks++;
            if (d0 !== exp[i] || v0 !== 1'b1 || f0 !== (i >= 3)) begin
                errors++;
                $display("FAIL fill[%0d] got dout=%0d v=%b full=%b exp %0d/1/%b",
                         i, d0, v0, f0, exp[i], (i >= 3));
            end
        end
    endtask

    task automatic test_gaps();
        logic [63:0] samp [3];
        logic [63:0] exp [3];
        samp = '{64'd30, 64'd40, 64'd50};
        exp  = '{64'd60, 64'd100, 64'd140};
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        drive(1'b1, 64'd10, 1'b0, 1'b0);
        drive(1'b1, 64'd20, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'($urandom), 1'b0, 1'b0);
            checks++;
            if (d0 !== 64'd30 || v0 !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold[%0d] got dout=%0d v=%b exp 30/0", i, d0, v0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, samp[i], 1'b0, 1'b0);
            checks++;
            if (d0 !== exp[i] || v0 !== 1'b1) begin
                errors++;
                $display("FAIL gap_resume[%0d] got dout=%0d v=%b exp %0d/1", i, d0, v0, exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, {64{1'b1}}, 1'b0, 1'b0);
        checks++;
        if (d0 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL ovf_sum got %0h exp fffffffffffffffc", d0);
        end
        checks++;
        if (d1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL ovf_avg got %0h exp ffffffffffffffff", d1);
        end
    endtask

    task automatic test_clear();
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        for (int i = 5; i <= 8; i++) drive(1'b1, 64'(i), 1'b0, 1'b0);
        checks++;
        if (d0 !== 64'd26 || f0 !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre got dout=%0d full=%b exp 26/1", d0, f0);
        end
        drive(1'b1, 64'd7, 1'b1, 1'b0);
        checks++;
        if (d0 !== 64'd7 || d1 !== 64'd1 || v0 !== 1'b1 || f0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_load got sum=%0d avg=%0d v=%b full=%b exp 7/1/1/0", d0, d1, v0, f0);
        end
        drive(1'b1, 64'd1, 1'b0, 1'b0);
        checks++;
        if (d0 !== 64'd8) begin
            errors++;
            $display("FAIL clr_next got %0d exp 8", d0);
        end
        drive(1'b0, 64'd99, 1'b1, 1'b0);
        checks++;
        if (d0 !== 64'd8 || v0 !== 1'b0 || f0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_idle got dout=%0d v=%b full=%b exp 8/0/0", d0, v0, f0);
        end
        drive(1'b1, 64'd2, 1'b0, 1'b0);
        checks++;
        if (d0 !== 64'd2) begin
            errors++;
            $display("FAIL clr_idle_next got %0d exp 2", d0);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 64'd9, 1'b0, 1'b0);
        drive(1'b1, 64'd9, 1'b1, 1'b1);
        checks++;
        if (d0 !== 64'd0 || v0 !== 1'b0 || f0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got dout=%0d v=%b full=%b exp 0/0/0", d0, v0, f0);
        end
        drive(1'b1, 64'd3, 1'b0, 1'b0);
        checks++;
        if (d0 !== 64'd3) begin
            errors++;
            $display("FAIL rst_mid_1 got %0d exp 3", d0);
        end
        drive(1'b1, 64'd3, 1'b0, 1'b0);
        checks++;
        if (d0 !== 64'd6) begin
            errors++;
            $display("FAIL rst_mid_2 got %0d exp 6", d0);
        end
    endtask

    task automatic test_random();
        drive(1'b0, 64'd0, 1'b0, 1'b1);
        for (int n = 0; n < 256; n++) begin
            logic        v, c, r;
            logic [63:0] d;
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 99) == 0);
            d = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) d = {64{1'b1}};
            drive(v, d, c, r);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_dout[i] !== exp_dout[i] || obs_v[i] !== exp_v || obs_full[i] !== exp_full[i]) begin
                    errors++;
                    $display("FAIL rand[%0d] inst%0d got dout=%0h v=%b full=%b exp %0h/%b/%b",
                             n, i, obs_dout[i], obs_v[i], obs_full[i], exp_dout[i], exp_v, exp_full[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        din_valid = 1'b0;
        din = '0;
        exp_v = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_gaps();
        test_overflow();
        test_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
